// File: rtl/add_sub_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : add_sub_seq_pkg                                            |
// | Purpose  : Shared constants and types for the chunked add/subtract    |
// |            datapath: FSM state encoding, default geometry and the     |
// |            mode-select values.                                        |
// | Ports    : none (package)                                             |
// | Config   : ADD_SUB_SAT_EN (saturating mode, see add_sub_seq)          |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package add_sub_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/add_sub_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : add_sub_seq_if                                             |
// | Purpose  : Operand/result handshake bundle for add_sub_seq.           |
// | Ports    : in_valid/in_ready, a, b, m, [sat]   - operand channel      |
// |            out_valid/out_ready, sum, c_out,                           |
// |            ovf, zero                           - result channel       |
// |            master = producer/consumer side, slave = the adder         |
// | Config   : ADD_SUB_SAT_EN adds the sat signal                         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface add_sub_seq_if
    import add_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
`ifdef ADD_SUB_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, m, out_ready,
`ifdef ADD_SUB_SAT_EN
        output sat,
`endif
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, m, out_ready,
`ifdef ADD_SUB_SAT_EN
        input  sat,
`endif
        output in_ready, out_valid, sum, c_out, ovf, zero
    );

endinterface
`default_nettype wire

// File: rtl/add_sub_seq_add_chunk.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : full_adder / add_chunk                                     |
// | Purpose  : full_adder is the one-bit cell; add_chunk chains CHUNK of  |
// |            them into a ripple slice and exposes the carry into its    |
// |            top bit so the caller can form signed overflow.            |
// | Ports    : a, b (CHUNK) , c_in   - slice operands and carry in        |
// |            sum (CHUNK), c_out    - slice result and carry out         |
// |            c_msb_in              - carry into the slice's top bit     |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module full_adder (
    input  wire logic a,
    input  wire logic b,
    input  wire logic ci,
    output logic      s,
    output logic      co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_chunk #(
    parameter int CHUNK = 4
) (
    input  wire logic [CHUNK-1:0] a,
    input  wire logic [CHUNK-1:0] b,
    input  wire logic             c_in,
    output logic      [CHUNK-1:0] sum,
    output logic                  c_out,
    output logic                  c_msb_in
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (sum[i]),
            .co (w_c[i+1])
        );
    end

    assign c_out    = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/add_sub_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : add_sub_seq                                                |
// | Purpose  : Multi-cycle two's-complement adder/subtractor. Processes   |
// |            CHUNK bits per clock through one ripple slice, LSB chunk   |
// |            first, with the carry registered between chunks. Reports   |
// |            carry-out, signed overflow and zero.                       |
// | Ports    : clk, rst_n (async, active-low)                             |
// |            bus : add_sub_seq_if.slave (operand + result handshakes)   |
// | Config   : ADD_SUB_SAT_EN - compiles in the sat input and saturation  |
// |            of the result on signed overflow                           |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module add_sub_seq
    import add_sub_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    add_sub_seq_if.slave  bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_cfg_check
        $error("add_sub_seq: WIDTH must be a multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;       // b already inverted for subtract
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef ADD_SUB_SAT_EN
    logic               sat_q, sat_d;
`endif
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [31:0]        w_lsb;
    logic [CHUNK-1:0]   w_ca, w_cb, w_csum;
    logic               w_cout, w_cmsb, w_ovf;
    logic [WIDTH-1:0]   w_acc_next, w_final;

    // Single slice, steered to the current chunk by idx.
    assign w_lsb = 32'(idx_q) * 32'(CHUNK);
    assign w_ca  = a_q[w_lsb +: CHUNK];
    assign w_cb  = b_q[w_lsb +: CHUNK];

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a        (w_ca),
        .b        (w_cb),
        .c_in     (carry_q),
        .sum      (w_csum),
        .c_out    (w_cout),
        .c_msb_in (w_cmsb)
    );

    // Only meaningful on the last chunk, where the slice top bit is the MSB.
    assign w_ovf = w_cmsb ^ w_cout;

    always_comb begin
        w_acc_next = acc_q;
        w_acc_next[w_lsb +: CHUNK] = w_csum;
    end

`ifdef ADD_SUB_SAT_EN
    // Clamp toward the sign of a: overflow can only push past the limit on a's side.
    always_comb begin
        w_final = w_acc_next;
        if (sat_q && w_ovf) begin
            w_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_final = w_acc_next;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
`ifdef ADD_SUB_SAT_EN
        sat_d   = sat_q;
`endif
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.m}};
                    carry_d = bus.m;
                    acc_d   = '0;
                    idx_d   = '0;
`ifdef ADD_SUB_SAT_EN
                    sat_d   = bus.sat;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = w_acc_next;
                carry_d = w_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    sum_d   = w_final;
                    c_out_d = w_cout;
                    ovf_d   = w_ovf;
                    zero_d  = (w_final == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
`ifdef ADD_SUB_SAT_EN
            sat_q   <= 1'b0;
`endif
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
`ifdef ADD_SUB_SAT_EN
            sat_q   <= sat_d;
`endif
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_add_sub_seq                                             |
// | Purpose  : Directed self-checking bench for add_sub_seq. Drives three |
// |            instances: 16/4 (default), 8/8 and 8/1, one at a time,     |
// |            through a shared driver selected by sel.                   |
// | Ports    : none                                                       |
// | Config   : ADD_SUB_SAT_EN enables the saturation vectors              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_add_sub_seq;
    import add_sub_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          sel = 0;
    logic        drv_in_valid = 1'b0;
    logic        drv_out_ready = 1'b0;
    logic [15:0] drv_a = '0;
    logic [15:0] drv_b = '0;
    logic        drv_m = 1'b0;
`ifdef ADD_SUB_SAT_EN
    logic        drv_sat = 1'b0;
`endif
    logic [15:0] prev_sum [3];

    add_sub_seq_if #(.WIDTH(16)) if_main ();
    add_sub_seq_if #(.WIDTH(8))  if_w8a ();
    add_sub_seq_if #(.WIDTH(8))  if_w8b ();

    add_sub_seq #(.WIDTH(16), .CHUNK(4)) u_dut    (.clk(clk), .rst_n(rst_n), .bus(if_main.slave));
    add_sub_seq #(.WIDTH(8),  .CHUNK(8)) u_dut_w8a (.clk(clk), .rst_n(rst_n), .bus(if_w8a.slave));
    add_sub_seq #(.WIDTH(8),  .CHUNK(1)) u_dut_w8b (.clk(clk), .rst_n(rst_n), .bus(if_w8b.slave));

    assign if_main.in_valid  = (sel == 0) && drv_in_valid;
    assign if_main.out_ready = (sel == 0) && drv_out_ready;
    assign if_main.a         = drv_a;
    assign if_main.b         = drv_b;
    assign if_main.m         = drv_m;
    assign if_w8a.in_valid   = (sel == 1) && drv_in_valid;
    assign if_w8a.out_ready  = (sel == 1) && drv_out_ready;
    assign if_w8a.a          = drv_a[7:0];
    assign if_w8a.b          = drv_b[7:0];
    assign if_w8a.m          = drv_m;
    assign if_w8b.in_valid   = (sel == 2) && drv_in_valid;
    assign if_w8b.out_ready  = (sel == 2) && drv_out_ready;
    assign if_w8b.a          = drv_a[7:0];
    assign if_w8b.b          = drv_b[7:0];
    assign if_w8b.m          = drv_m;
`ifdef ADD_SUB_SAT_EN
    assign if_main.sat       = drv_sat;
    assign if_w8a.sat        = 1'b0;
    assign if_w8b.sat        = 1'b0;
`endif

    logic        obs_in_ready, obs_out_valid, obs_c, obs_ovf, obs_zero;
    logic [15:0] obs_sum;

    always_comb begin
        obs_in_ready  = if_main.in_ready;
        obs_out_valid = if_main.out_valid;
        obs_sum       = if_main.sum;
        obs_c         = if_main.c_out;
        obs_ovf       = if_main.ovf;
        obs_zero      = if_main.zero;
        if (sel == 1) begin
            obs_in_ready  = if_w8a.in_ready;
            obs_out_valid = if_w8a.out_valid;
            obs_sum       = {8'h00, if_w8a.sum};
            obs_c         = if_w8a.c_out;
            obs_ovf       = if_w8a.ovf;
            obs_zero      = if_w8a.zero;
        end else if (sel == 2) begin
            obs_in_ready  = if_w8b.in_ready;
            obs_out_valid = if_w8b.out_valid;
            obs_sum       = {8'h00, if_w8b.sum};
            obs_c         = if_w8b.c_out;
            obs_ovf       = if_w8b.ovf;
            obs_zero      = if_w8b.zero;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction on instance s; checks acceptance, latency, held
    // output during RUN, the result and flags, and optionally the drain.
    task automatic do_op(input int s, input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic [15:0] es, input logic ec,
                         input logic eo, input logic ez, input int elat, input bit rel);
        int cnt;
        @(negedge clk);
        sel = s; drv_a = a; drv_b = b; drv_m = m; drv_in_valid = 1'b1;
        #1 check_eq("in_ready_idle", obs_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        drv_in_valid = 1'b0;
        #1 check_eq("sum_held_run", obs_sum, prev_sum[s]);
        cnt = 0;
        while (!obs_out_valid && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            #1;
        end
        check_eq("latency", cnt, elat);
        check_eq("sum", obs_sum, es);
        check_eq("c_out", obs_c, ec);
        check_eq("ovf", obs_ovf, eo);
        check_eq("zero", obs_zero, ez);
        prev_sum[s] = es;
        if (rel) begin
            @(negedge clk);
            drv_out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1 check_eq("drain_out_valid", obs_out_valid, 0);
            check_eq("drain_in_ready", obs_in_ready, 1);
            drv_out_ready = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev_sum[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1 check_eq("rst_in_ready", obs_in_ready, 1);
        check_eq("rst_out_valid", obs_out_valid, 0);
        check_eq("rst_sum", obs_sum, 0);
        check_eq("rst_flags", {obs_c, obs_ovf, obs_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main function, defaults 16/4
        do_op(0, 16'd2733, 16'd2732, MODE_ADD, 16'd5465, 1'b0, 1'b0, 1'b0, 4, 1);
        do_op(0, 16'd2733, 16'd2732, MODE_SUB, 16'd1,    1'b1, 1'b0, 1'b0, 4, 1);
        do_op(0, 16'd5,    16'd5,    MODE_SUB, 16'd0,    1'b1, 1'b0, 1'b1, 4, 1);
        do_op(0, 16'h7FFF, 16'h0001, MODE_ADD, 16'h8000, 1'b0, 1'b1, 1'b0, 4, 1);
        do_op(0, 16'hFFFF, 16'h0001, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 4, 1);
        do_op(0, 16'h8000, 16'h0001, MODE_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4, 1);
        do_op(0, 16'h00F0, 16'h0010, MODE_ADD, 16'h0100, 1'b0, 1'b0, 1'b0, 4, 1);

`ifdef ADD_SUB_SAT_EN
        drv_sat = 1'b1;
        do_op(0, 16'h7FFF, 16'h0001, MODE_ADD, 16'h7FFF, 1'b0, 1'b1, 1'b0, 4, 1);
        do_op(0, 16'h8000, 16'h0001, MODE_SUB, 16'h8000, 1'b1, 1'b1, 1'b0, 4, 1);
        do_op(0, 16'd2733, 16'd2732, MODE_SUB, 16'd1,    1'b1, 1'b0, 1'b0, 4, 1);
        drv_sat = 1'b0;
`endif

        // Backpressure: hold in DONE, offer a second operand that must be ignored
        do_op(0, 16'd2733, 16'd2732, MODE_SUB, 16'd1, 1'b1, 1'b0, 1'b0, 4, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drv_a = 16'h1234; drv_b = 16'h1111; drv_m = MODE_ADD; drv_in_valid = 1'b1;
            #1 check_eq("bp_out_valid", obs_out_valid, 1);
            check_eq("bp_in_ready", obs_in_ready, 0);
            check_eq("bp_sum", obs_sum, 16'd1);
            check_eq("bp_c_out", obs_c, 1);
        end
        @(negedge clk);
        drv_in_valid = 1'b0;
        drv_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1 check_eq("bp_rel_in_ready", obs_in_ready, 1);
        check_eq("bp_rel_out_valid", obs_out_valid, 0);
        check_eq("bp_rel_sum", obs_sum, 16'd1);
        drv_out_ready = 1'b0;

        // Reset two cycles into RUN; outputs clear without a clock edge
        @(negedge clk);
        drv_a = 16'h1234; drv_b = 16'h0001; drv_m = MODE_ADD; drv_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("mr_sum", obs_sum, 0);
        check_eq("mr_flags", {obs_c, obs_ovf, obs_zero}, 0);
        check_eq("mr_out_valid", obs_out_valid, 0);
        check_eq("mr_in_ready", obs_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum[0] = '0;
        do_op(0, 16'd2733, 16'd2732, MODE_ADD, 16'd5465, 1'b0, 1'b0, 1'b0, 4, 1);

        // Geometry sweep on 8-bit instances
        do_op(1, 16'h00FF, 16'h0001, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 1, 1);
        do_op(2, 16'h00FF, 16'h0001, MODE_ADD, 16'h0000, 1'b1, 1'b0, 1'b1, 8, 1);
        do_op(2, 16'h007F, 16'h0001, MODE_ADD, 16'h0080, 1'b0, 1'b1, 1'b0, 8, 1);
        do_op(1, 16'h0003, 16'h0005, MODE_SUB, 16'h00FE, 1'b0, 1'b0, 1'b0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
